// File: rtl/screen_flow_controller.sv
// Top-level screen sequencer: START -> PLAYING -> END -> START around the main game screen.
// Issues the one-cycle start pulse, picks the VGA pixel source and tracks the best score.
module screen_flow_controller #(
  parameter int unsigned WIN_SCORE       = 9,
  parameter int unsigned ARM_FRAMES      = 2,
  parameter int unsigned END_HOLD_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       key5IsPressed,
  input  logic [3:0] life,
  input  logic [3:0] score,
  input  logic [7:0] RGB_screen_main,
  input  logic [7:0] RGB_screen_start,
  input  logic [7:0] RGB_screen_end,
  output logic       start,
  output logic [7:0] RGB_out,
  output logic [1:0] screen_state,
  output logic       end_win,
  output logic [3:0] best_score
);

  typedef enum logic [1:0] {
    S_START = 2'b00,
    S_PLAY  = 2'b01,
    S_END   = 2'b10
  } state_t;

  localparam logic [3:0] WIN_L  = 4'(WIN_SCORE);
  localparam logic [3:0] ARM_L  = 4'(ARM_FRAMES);
  localparam logic [7:0] HOLD_L = 8'(END_HOLD_FRAMES);

  state_t     state_q, state_d;
  logic       key5_prev_q;
  logic       start_q, start_d;
  logic [3:0] arm_q, arm_d;
  logic [7:0] hold_q, hold_d;
  logic       end_win_q, end_win_d;
  logic [3:0] best_q, best_d;
  logic [7:0] rgb_q, rgb_d;

  logic key5_rise;
  logic armed_eval;
  logic win_hit;
  logic lose_hit;

  assign key5_rise  = key5IsPressed & ~key5_prev_q;
  // Counters are only trusted once the arm window has fully elapsed.
  assign armed_eval = startOfFrame && (arm_q == ARM_L);
  assign win_hit    = armed_eval && (score >= WIN_L);
  assign lose_hit   = armed_eval && (life == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_START;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_START: if (key5_rise) state_d = S_PLAY;
      S_PLAY:  if (win_hit || lose_hit) state_d = S_END;
      S_END:   if (key5_rise && (hold_q == HOLD_L)) state_d = S_START;
      default: state_d = S_START;
    endcase
  end

  always_comb begin
    start_d   = (state_q == S_START) && key5_rise;
    arm_d     = 4'd0;
    hold_d    = 8'd0;
    end_win_d = end_win_q;
    best_d    = best_q;
    rgb_d     = 8'd0;

    if (state_q == S_PLAY && startOfFrame && (arm_q < ARM_L)) begin
      arm_d = arm_q + 4'd1;
    end else if (state_q == S_PLAY) begin
      arm_d = arm_q;
    end

    if (state_q == S_END && startOfFrame && (hold_q < HOLD_L)) begin
      hold_d = hold_q + 8'd1;
    end else if (state_q == S_END) begin
      hold_d = hold_q;
    end

    // Win outranks loss when both are seen on the same frame.
    if (state_q == S_PLAY && state_d == S_END) begin
      end_win_d = win_hit;
      best_d    = (score > best_q) ? score : best_q;
    end

    case (state_q)
      S_START: rgb_d = RGB_screen_start;
      S_PLAY:  rgb_d = RGB_screen_main;
      S_END:   rgb_d = RGB_screen_end;
      default: rgb_d = 8'd0;
    endcase
  end

  // Key history resets high so a key already held at reset yields no edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key5_prev_q <= 1'b1;
      start_q     <= 1'b0;
      arm_q       <= 4'd0;
      hold_q      <= 8'd0;
      end_win_q   <= 1'b0;
      best_q      <= 4'd0;
      rgb_q       <= 8'd0;
    end else begin
      key5_prev_q <= key5IsPressed;
      start_q     <= start_d;
      arm_q       <= arm_d;
      hold_q      <= hold_d;
      end_win_q   <= end_win_d;
      best_q      <= best_d;
      rgb_q       <= rgb_d;
    end
  end

  assign start        = start_q;
  assign RGB_out      = rgb_q;
  assign screen_state = state_q;
  assign end_win      = end_win_q;
  assign best_score   = best_q;

endmodule

// File: tb/tb_screen_flow_controller.sv
// Scoreboard bench for screen_flow_controller: stimulus queues timed expectations,
// a negedge monitor pops and compares them and polices the start pulse.
module tb_screen_flow_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       startOfFrame;
  logic       key5IsPressed;
  logic [3:0] life;
  logic [3:0] score;
  logic [7:0] RGB_screen_main;
  logic [7:0] RGB_screen_start;
  logic [7:0] RGB_screen_end;
  logic       start;
  logic [7:0] RGB_out;
  logic [1:0] screen_state;
  logic       end_win;
  logic [3:0] best_score;

  screen_flow_controller #(
    .WIN_SCORE(9),
    .ARM_FRAMES(2),
    .END_HOLD_FRAMES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .startOfFrame(startOfFrame),
    .key5IsPressed(key5IsPressed),
    .life(life),
    .score(score),
    .RGB_screen_main(RGB_screen_main),
    .RGB_screen_start(RGB_screen_start),
    .RGB_screen_end(RGB_screen_end),
    .start(start),
    .RGB_out(RGB_out),
    .screen_state(screen_state),
    .end_win(end_win),
    .best_score(best_score)
  );

  always #5 clk = ~clk;

  localparam int SEL_STATE = 0;
  localparam int SEL_START = 1;
  localparam int SEL_RGB   = 2;
  localparam int SEL_WIN   = 3;
  localparam int SEL_BEST  = 4;

  typedef struct {
    int         cyc;
    int         sel;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t chkq[$];
  int   startq[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [7:0] dut_val(input int sel);
    case (sel)
      SEL_STATE: return {6'd0, screen_state};
      SEL_START: return {7'd0, start};
      SEL_RGB:   return RGB_out;
      SEL_WIN:   return {7'd0, end_win};
      SEL_BEST:  return {4'd0, best_score};
      default:   return 8'hxx;
    endcase
  endfunction

  task automatic chk(input int sel, input logic [7:0] val, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.sel  = sel;
    e.val  = val;
    e.name = name;
    chkq.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sof();
    startOfFrame = 1'b1;
    step(1);
    startOfFrame = 1'b0;
  endtask

  task automatic press(input bit expect_start);
    key5IsPressed = 1'b1;
    if (expect_start) startq.push_back(cyc + 1);
    step(1);
    key5IsPressed = 1'b0;
    step(1);
  endtask

  task automatic leave_end();
    repeat (4) sof();
    press(1'b0);
    chk(SEL_STATE, 8'd0, "leave_end_state");
  endtask

  // Monitor: compares every due expectation and every observed start pulse.
  always @(negedge clk) begin
    while (startq.size() > 0 && startq[0] < cyc) begin
      checks++;
      failures++;
      $display("FAIL start_missing cyc=%0d got=0 exp=1", startq[0]);
      void'(startq.pop_front());
    end
    if (start !== 1'b0) begin
      checks++;
      if (start === 1'b1 && startq.size() > 0 && startq[0] == cyc) begin
        $display("ok   start_pulse cyc=%0d", cyc);
        void'(startq.pop_front());
      end else begin
        failures++;
        $display("FAIL start_unexpected cyc=%0d got=%b exp=0", cyc, start);
      end
    end
    while (chkq.size() > 0 && chkq[0].cyc <= cyc) begin
      exp_t e;
      logic [7:0] got;
      e = chkq.pop_front();
      got = dut_val(e.sel);
      checks++;
      if (e.cyc != cyc || got !== e.val) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%0h exp=%0h", e.name, cyc, got, e.val);
      end else begin
        $display("ok   %s cyc=%0d val=%0h", e.name, cyc, got);
      end
    end
    if (done) begin
      checks++;
      if (chkq.size() != 0 || startq.size() != 0) begin
        failures++;
        $display("FAIL queues_drained got=%0d/%0d exp=0/0", chkq.size(), startq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    startOfFrame     = 1'b0;
    key5IsPressed    = 1'b1;
    life             = 4'd3;
    score            = 4'd0;
    RGB_screen_start = 8'hE0;
    RGB_screen_main  = 8'h1C;
    RGB_screen_end   = 8'h03;

    // Reset state, key held through release gives no edge.
    step(2);
    chk(SEL_STATE, 8'd0, "rst_state");
    chk(SEL_START, 8'd0, "rst_start");
    chk(SEL_RGB,   8'd0, "rst_rgb");
    chk(SEL_WIN,   8'd0, "rst_end_win");
    chk(SEL_BEST,  8'd0, "rst_best");
    reset = 1'b0;
    step(1);
    chk(SEL_RGB, 8'hE0, "start_rgb");
    step(2);
    chk(SEL_STATE, 8'd0, "held_key_state");
    key5IsPressed = 1'b0;
    step(1);

    // Game 1: lose with score 5 once armed.
    press(1'b1);
    chk(SEL_STATE, 8'd1, "play_state");
    chk(SEL_RGB,   8'h1C, "play_rgb");
    press(1'b0);
    chk(SEL_STATE, 8'd1, "play_key_ignored");
    life  = 4'd0;
    score = 4'd5;
    sof();
    chk(SEL_STATE, 8'd1, "arm_frame1");
    sof();
    chk(SEL_STATE, 8'd1, "arm_frame2");
    sof();
    chk(SEL_STATE, 8'd2, "lose_state");
    chk(SEL_WIN,   8'd0, "lose_end_win");
    chk(SEL_BEST,  8'd5, "lose_best5");
    chk(SEL_RGB,   8'h1C, "end_rgb_lag");
    step(1);
    chk(SEL_RGB, 8'h03, "end_rgb");

    // END hold: too early press ignored, saturation then leave without start.
    sof();
    sof();
    press(1'b0);
    chk(SEL_STATE, 8'd2, "hold_early");
    sof();
    sof();
    sof();
    press(1'b0);
    chk(SEL_STATE, 8'd0, "hold_leave");
    chk(SEL_START, 8'd0, "hold_leave_start");
    step(1);
    chk(SEL_RGB, 8'hE0, "back_start_rgb");

    // Games scoring 7 then 3: best holds 7.
    score = 4'd7;
    press(1'b1);
    repeat (3) sof();
    chk(SEL_STATE, 8'd2, "g7_state");
    chk(SEL_BEST,  8'd7, "g7_best");
    leave_end();
    score = 4'd3;
    press(1'b1);
    repeat (3) sof();
    chk(SEL_STATE, 8'd2, "g3_state");
    chk(SEL_BEST,  8'd7, "g3_best");
    leave_end();

    // Win and lose on the same frame: win wins.
    life  = 4'd3;
    score = 4'd0;
    press(1'b1);
    sof();
    sof();
    chk(SEL_STATE, 8'd1, "win_armed_wait");
    score = 4'd9;
    life  = 4'd0;
    sof();
    chk(SEL_STATE, 8'd2, "win_state");
    chk(SEL_WIN,   8'd1, "win_end_win");
    chk(SEL_BEST,  8'd9, "win_best");
    leave_end();
    chk(SEL_WIN, 8'd1, "win_held");

    // Mid-game asynchronous reset, sampled before any further clock edge.
    life  = 4'd3;
    score = 4'd0;
    press(1'b1);
    sof();
    @(posedge clk);
    #2;
    reset = 1'b1;
    chk(SEL_STATE, 8'd0, "async_state");
    chk(SEL_RGB,   8'd0, "async_rgb");
    chk(SEL_BEST,  8'd0, "async_best");
    chk(SEL_WIN,   8'd0, "async_end_win");
    step(1);
    reset = 1'b0;
    step(1);
    chk(SEL_RGB, 8'hE0, "post_rst_rgb");
    RGB_screen_start = 8'h5A;
    step(1);
    chk(SEL_RGB, 8'h5A, "rgb_input_follow");

    step(2);
    done = 1'b1;
  end

endmodule
